wptr_full_ctrl: RTL and testbench
=================================

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; SHALL be a power of two, 4 or more.
REQ-002 Parameter AFULL_THRESH, default DEPTH-2, w_level at or above which w_almost_full SHALL assert; range 1..DEPTH.
REQ-003 Derived width PW = $clog2(DEPTH)+1 (pointer width) and AW = PW-1 (address width).
REQ-004 w_clk  in  1  write-domain clock; the only clock.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 w_en  in  1  write request from producer.
REQ-007 wsync_ptr2  in  PW  Gray read pointer, already two-flop synchronised into w_clk.
REQ-008 ovf_clr  in  1  clears w_overflow.
REQ-009 w_accept  out  1  memory write strobe; write accepted this cycle.
REQ-010 w_addr  out  AW  memory write address.
REQ-011 wptr  out  PW  Gray write pointer, registered, for read-domain synchroniser.
REQ-012 w_full  out  1  FIFO full, registered.
REQ-013 w_almost_full  out  1  level at or above AFULL_THRESH, registered.
REQ-014 w_level  out  PW  conservative occupancy, 0..DEPTH, registered.
REQ-015 w_overflow  out  1  sticky: write attempted while full.

Function
REQ-016 w_accept SHALL equal w_en AND NOT w_full, combinationally in the same cycle.
REQ-017 Binary pointer wbin (PW bits) SHALL increment by 1 modulo 2^PW on each cycle with w_accept=1, else hold.
REQ-018 wbin_next = wbin + w_accept; wgray_next = wbin_next XOR (wbin_next >> 1); both registered on the w_clk edge.
REQ-019 w_addr SHALL equal wbin[AW-1:0]; wptr SHALL equal registered Gray of wbin; each wptr change SHALL flip exactly one bit.
REQ-020 w_full_next = (wgray_next == {~wsync_ptr2[PW-1:PW-2], wsync_ptr2[PW-3:0]}); registered into w_full.
REQ-021 rbin_sync = Gray-to-binary of wsync_ptr2; w_level_next = (wbin_next - rbin_sync) modulo 2^PW; registered into w_level.
REQ-022 w_almost_full_next = (w_level_next >= AFULL_THRESH); registered.
REQ-023 Latency: w_full, w_level and w_almost_full SHALL reflect a write 1 cycle after the accepting edge, and a read-pointer change 1 cycle after wsync_ptr2 changes.
REQ-024 Full boundary: a write in the cycle that fills the last entry SHALL be accepted; w_full SHALL assert on that edge; no write SHALL be accepted while w_full=1.
REQ-025 Simultaneous write and read-pointer advance while full-1: w_full_next SHALL use the new wsync_ptr2 and SHALL NOT assert.
REQ-026 Wrap: wbin SHALL roll from 2^PW-1 to 0 without affecting full or level correctness.
REQ-027 w_overflow SHALL set on the edge after any cycle with w_en=1 and w_full=1.
REQ-028 w_overflow SHALL clear on the edge after any cycle with ovf_clr=1; if set and clear coincide, set SHALL win.
REQ-029 w_level SHALL never exceed DEPTH; stale wsync_ptr2 SHALL only overestimate occupancy.

Reset
REQ-030 On rst_n low, wbin, wptr, w_addr, w_level SHALL be 0 and w_full, w_almost_full, w_overflow SHALL be 0, asynchronously.
REQ-031 w_accept SHALL be 0 during reset.
REQ-032 Reset mid-operation SHALL discard all pointer state; the first write after release SHALL use w_addr 0.
REQ-033 Reset release SHALL be synchronous to w_clk; the first update SHALL occur on the first rising edge with rst_n high.

Structure
REQ-034 Shared package fifo_pkg SHALL hold the default DEPTH, the PW/AW derivation and the bin-to-Gray/Gray-to-bin functions, for reuse by the read-side controller.
REQ-035 One sub-module gray2bin (parameter W) SHALL perform the wsync_ptr2 conversion.
REQ-036 The block SHALL contain no memory array and no synchroniser flops.

Verification (DEPTH=8, AFULL_THRESH=6, wsync_ptr2 held 0 unless stated)
REQ-037 Reset, then 8 back-to-back w_en -> w_addr 0..7; w_full=1 after the 8th edge; w_level=8; wptr=4'b1100.
REQ-038 Full, then w_en for 2 cycles -> w_accept=0, wptr holds, w_overflow=1 and stays set; ovf_clr pulse -> w_overflow=0 next edge.
REQ-039 6 writes -> w_almost_full=1 after the 6th edge, w_level=6; at 5 writes w_almost_full=0.
REQ-040 Full, wsync_ptr2 set to Gray(3) -> w_full=0 and w_level=5 one cycle later; write accepted at w_addr 0.
REQ-041 Continuous write/read for 40 entries with wsync_ptr2 tracking two cycles late -> wbin wraps, no false full, every wptr step one-bit, w_level never above 8.
REQ-042 rst_n low mid-burst at w_level=4 -> all outputs 0 immediately; next write at w_addr 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: default depth, pointer width derivation and Gray conversions.
// The read-side controller uses these helpers as well.
package fifo_pkg;

  localparam int unsigned DEPTH_DEF = 8;

  // Pointer carries one extra wrap bit above the address bits.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down. Zero-extended narrow inputs convert correctly.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Width-parameterised Gray-to-binary converter, purely combinational.
module gray2bin
  import fifo_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  logic [31:0] bin_wide;

  always_comb begin
    bin_wide = gray2bin(32'(gray));
    bin      = bin_wide[W-1:0];
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, full/almost-full and occupancy control for an async FIFO.
// Works against a read pointer that has already been synchronised into w_clk.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter  int unsigned DEPTH        = DEPTH_DEF,
  parameter  int unsigned AFULL_THRESH = DEPTH - 2,
  localparam int unsigned PW           = ptr_width(DEPTH),
  localparam int unsigned AW           = addr_width(DEPTH)
) (
  input  logic          w_clk,
  input  logic          rst_n,
  input  logic          w_en,
  input  logic [PW-1:0] wsync_ptr2,
  input  logic          ovf_clr,
  output logic          w_accept,
  output logic [AW-1:0] w_addr,
  output logic [PW-1:0] wptr,
  output logic          w_full,
  output logic          w_almost_full,
  output logic [PW-1:0] w_level,
  output logic          w_overflow
);

  // Elaboration-time parameter sanity.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("wptr_full_ctrl: DEPTH must be a power of two, 4 or more");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_thresh
    $error("wptr_full_ctrl: AFULL_THRESH must lie in 1..DEPTH");
  end

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] level_next;
  logic [31:0]   gray_wide;
  logic          full_next;
  logic          afull_next;
  logic          ovf_next;

  gray2bin #(
    .W (PW)
  ) u_rsync_g2b (
    .gray (wsync_ptr2),
    .bin  (rbin_sync)
  );

  // Accept strobe is gated by reset so no write leaks out while held in reset.
  always_comb begin
    w_accept = rst_n & w_en & ~w_full;
  end

  // Next pointer, full, level and overflow; all evaluated against the current wsync_ptr2.
  always_comb begin
    wbin_next  = wbin + PW'(w_accept);
    gray_wide  = bin2gray(32'(wbin_next));
    wgray_next = gray_wide[PW-1:0];
    full_cmp   = {~wsync_ptr2[PW-1:PW-2], wsync_ptr2[PW-3:0]};
    full_next  = (wgray_next == full_cmp);
    level_next = wbin_next - rbin_sync;
    afull_next = (32'(level_next) >= AFULL_THRESH);
    ovf_next   = (w_en & w_full) | (w_overflow & ~ovf_clr);
  end

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin          <= '0;
      wptr          <= '0;
      w_full        <= 1'b0;
      w_almost_full <= 1'b0;
      w_level       <= '0;
      w_overflow    <= 1'b0;
    end else begin
      wbin          <= wbin_next;
      wptr          <= wgray_next;
      w_full        <= full_next;
      w_almost_full <= afull_next;
      w_level       <= level_next;
      w_overflow    <= ovf_next;
    end
  end

  assign w_addr = wbin[AW-1:0];

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl at DEPTH=8, AFULL_THRESH=6.
module tb_wptr_full_ctrl;

  logic       w_clk;
  logic       rst_n;
  logic       w_en;
  logic [3:0] wsync_ptr2;
  logic       ovf_clr;
  logic       w_accept;
  logic [2:0] w_addr;
  logic [3:0] wptr;
  logic       w_full;
  logic       w_almost_full;
  logic [3:0] w_level;
  logic       w_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  wptr_full_ctrl #(
    .DEPTH        (8),
    .AFULL_THRESH (6)
  ) dut (
    .w_clk         (w_clk),
    .rst_n         (rst_n),
    .w_en          (w_en),
    .wsync_ptr2    (wsync_ptr2),
    .ovf_clr       (ovf_clr),
    .w_accept      (w_accept),
    .w_addr        (w_addr),
    .wptr          (wptr),
    .w_full        (w_full),
    .w_almost_full (w_almost_full),
    .w_level       (w_level),
    .w_overflow    (w_overflow)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct {
    logic       en;
    logic [3:0] sync;
    logic       clr;
    logic       acc;
    logic [2:0] addr;
    logic [3:0] ptr;
    logic       full;
    logic       af;
    logic [3:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic en, input logic [3:0] sync, input logic clr,
                              input logic acc, input logic [2:0] addr, input logic [3:0] ptr,
                              input logic full, input logic af, input logic [3:0] lvl,
                              input logic ovf);
    vec_t v;
    v.en = en; v.sync = sync; v.clr = clr; v.acc = acc; v.addr = addr;
    v.ptr = ptr; v.full = full; v.af = af; v.lvl = lvl; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge w_clk);
    rst_n = 1'b0;
    w_en = 1'b0; wsync_ptr2 = 4'd0; ovf_clr = 1'b0;
    @(negedge w_clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] prev_ptr;
  logic [3:0] sb;
  logic [3:0] exp_lvl;

  initial begin
    rst_n = 1'b0; w_en = 1'b1; wsync_ptr2 = 4'd0; ovf_clr = 1'b0;

    // Table: writes to full, overflow, read-pointer advances, coincident set/clear.
    vq.push_back(mk(1, 4'b0000, 0, 1, 3'd1, 4'b0001, 0, 0, 4'd1, 0));
    vq.push_back(mk(1, 4'b0000, 0, 1, 3'd2, 4'b0011, 0, 0, 4'd2, 0));
    vq.push_back(mk(1, 4'b0000, 0, 1, 3'd3, 4'b0010, 0, 0, 4'd3, 0));
    vq.push_back(mk(1, 4'b0000, 0, 1, 3'd4, 4'b0110, 0, 0, 4'd4, 0));
    vq.push_back(mk(1, 4'b0000, 0, 1, 3'd5, 4'b0111, 0, 0, 4'd5, 0));
    vq.push_back(mk(1, 4'b0000, 0, 1, 3'd6, 4'b0101, 0, 1, 4'd6, 0));
    vq.push_back(mk(1, 4'b0000, 0, 1, 3'd7, 4'b0100, 0, 1, 4'd7, 0));
    vq.push_back(mk(1, 4'b0000, 0, 1, 3'd0, 4'b1100, 1, 1, 4'd8, 0));
    vq.push_back(mk(1, 4'b0000, 0, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1));
    vq.push_back(mk(1, 4'b0000, 0, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1));
    vq.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1));
    vq.push_back(mk(0, 4'b0000, 1, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 0));
    vq.push_back(mk(0, 4'b0010, 0, 0, 3'd0, 4'b1100, 0, 0, 4'd5, 0));
    vq.push_back(mk(1, 4'b0010, 0, 1, 3'd1, 4'b1101, 0, 1, 4'd6, 0));
    vq.push_back(mk(1, 4'b0010, 0, 1, 3'd2, 4'b1111, 0, 1, 4'd7, 0));
    vq.push_back(mk(1, 4'b0010, 0, 1, 3'd3, 4'b1110, 1, 1, 4'd8, 0));
    vq.push_back(mk(1, 4'b0010, 1, 0, 3'd3, 4'b1110, 1, 1, 4'd8, 1));
    vq.push_back(mk(0, 4'b0010, 1, 0, 3'd3, 4'b1110, 1, 1, 4'd8, 0));
    vq.push_back(mk(0, 4'b0110, 0, 0, 3'd3, 4'b1110, 0, 1, 4'd7, 0));
    vq.push_back(mk(1, 4'b0111, 0, 1, 3'd4, 4'b1010, 0, 1, 4'd7, 0));
    vq.push_back(mk(1, 4'b0111, 0, 1, 3'd5, 4'b1011, 1, 1, 4'd8, 0));

    // Reset values, with w_en held high.
    #12;
    chk("rst_accept", 32'(w_accept), 32'd0);
    chk("rst_addr",   32'(w_addr),   32'd0);
    chk("rst_wptr",   32'(wptr),     32'd0);
    chk("rst_full",   32'(w_full),   32'd0);
    chk("rst_afull",  32'(w_almost_full), 32'd0);
    chk("rst_level",  32'(w_level),  32'd0);
    chk("rst_ovf",    32'(w_overflow), 32'd0);
    @(negedge w_clk);
    rst_n = 1'b1; w_en = 1'b0;

    foreach (vq[i]) begin
      @(negedge w_clk);
      w_en = vq[i].en; wsync_ptr2 = vq[i].sync; ovf_clr = vq[i].clr;
      #1;
      chk($sformatf("v%0d_accept", i), 32'(w_accept), 32'(vq[i].acc));
      @(posedge w_clk);
      #1;
      chk($sformatf("v%0d_addr", i),  32'(w_addr),  32'(vq[i].addr));
      chk($sformatf("v%0d_wptr", i),  32'(wptr),    32'(vq[i].ptr));
      chk($sformatf("v%0d_full", i),  32'(w_full),  32'(vq[i].full));
      chk($sformatf("v%0d_afull", i), 32'(w_almost_full), 32'(vq[i].af));
      chk($sformatf("v%0d_level", i), 32'(w_level), 32'(vq[i].lvl));
      chk($sformatf("v%0d_ovf", i),   32'(w_overflow), 32'(vq[i].ovf));
    end
    w_en = 1'b0; ovf_clr = 1'b0;

    // Streaming with the read pointer two cycles behind; wraps the 4-bit pointer twice.
    do_reset();
    prev_ptr = 4'd0;
    for (int c = 0; c < 40; c++) begin
      @(negedge w_clk);
      w_en = 1'b1;
      sb = (c >= 2) ? 4'(c - 2) : 4'd0;
      wsync_ptr2 = sb ^ (sb >> 1);
      #1;
      chk($sformatf("s%0d_accept", c), 32'(w_accept), 32'd1);
      @(posedge w_clk);
      #1;
      exp_lvl = (c >= 2) ? 4'd3 : 4'(c + 1);
      chk($sformatf("s%0d_onebit", c), 32'($countones(wptr ^ prev_ptr)), 32'd1);
      chk($sformatf("s%0d_level", c), 32'(w_level), 32'(exp_lvl));
      chk($sformatf("s%0d_full", c), 32'(w_full), 32'd0);
      chk($sformatf("s%0d_addr", c), 32'(w_addr), 32'((c + 1) % 8));
      chk($sformatf("s%0d_lvl_max", c), 32'(w_level <= 4'd8), 32'd1);
      prev_ptr = wptr;
    end
    w_en = 1'b0;

    // Reset mid-burst at level 4.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge w_clk);
      w_en = 1'b1;
    end
    @(posedge w_clk);
    #1;
    chk("mid_level4", 32'(w_level), 32'd4);
    @(negedge w_clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_accept", 32'(w_accept), 32'd0);
    chk("mid_addr",   32'(w_addr),   32'd0);
    chk("mid_wptr",   32'(wptr),     32'd0);
    chk("mid_full",   32'(w_full),   32'd0);
    chk("mid_afull",  32'(w_almost_full), 32'd0);
    chk("mid_level",  32'(w_level),  32'd0);
    chk("mid_ovf",    32'(w_overflow), 32'd0);
    @(negedge w_clk);
    rst_n = 1'b1;
    #1;
    chk("post_accept", 32'(w_accept), 32'd1);
    chk("post_addr0",  32'(w_addr),   32'd0);
    @(posedge w_clk);
    #1;
    chk("post_addr1",  32'(w_addr),  32'd1);
    chk("post_wptr",   32'(wptr),    32'b0001);
    chk("post_level",  32'(w_level), 32'd1);
    w_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
